// File: rtl/uart_program_loader_pkg.sv
// Shared state encodings and global widths for the UART program loader.
// Imported by the byte receiver and the word loader.
package uart_program_loader_pkg;

  localparam int ISA_WIDTH     = 32;
  localparam int DEF_ROM_DEPTH = 14;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_RECV,
    L_WRITE,
    L_DONE
  } ld_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-FF synchronizer, mid-bit sampling, framing check.
// byte_valid and frame_err are single-cycle pulses.
module uart_byte_rx
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned DIV  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);

  logic      rx_s1, rx_s2, rx_prev;
  rx_state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic       vld_d, ferr_d;
  logic       start_edge;

  assign start_edge = rx_prev & ~rx_s2;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q + 1'b1;
    bit_d  = bit_q;
    sh_d   = sh_q;
    vld_d  = 1'b0;
    ferr_d = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (start_edge) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          st_d  = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d = '0;
          sh_d  = {rx_s2, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == CW'(DIV - 1)) begin
          cnt_d  = '0;
          st_d   = RX_IDLE;
          vld_d  = rx_s2;
          ferr_d = ~rx_s2;
        end
      end
    endcase
  end

  // Synchronizer idles high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      st_q       <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      byte_valid <= vld_d;
      frame_err  <= ferr_d;
    end
  end

  assign byte_data = sh_q;

endmodule

// File: rtl/uart_program_loader.sv
// Packs UART bytes little-endian into words and writes them to IMEM/DMEM.
// Address MSB selects data memory; a session ends on wrap or idle timeout.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned ROM_DEPTH    = DEF_ROM_DEPTH,
  parameter int unsigned IDLE_TIMEOUT = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  input  logic                 session_start,
  output logic                 uart_write_enable,
  output logic [ROM_DEPTH:0]   uart_addr,
  output logic [ISA_WIDTH-1:0] uart_data,
  output logic                 uart_busy,
  output logic                 uart_done,
  output logic                 uart_frame_error
);

  localparam int unsigned TW = $clog2(IDLE_TIMEOUT);

  logic       rx_valid, rx_ferr, bv_q;
  logic [7:0] rx_data, bd_q;

  uart_byte_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uart_rx),
    .byte_valid(rx_valid),
    .byte_data (rx_data),
    .frame_err (rx_ferr)
  );

  ld_state_t l_q, l_d;
  logic [ROM_DEPTH:0]   wa_q, wa_d, addr_d;
  logic [1:0]           bi_q, bi_d;
  logic [TW-1:0]        tc_q, tc_d;
  logic                 seen_q, seen_d;
  logic [ISA_WIDTH-1:0] word_q, word_d, data_d;
  logic                 we_d, ferr_d;

  always_comb begin
    l_d    = l_q;
    wa_d   = wa_q;
    bi_d   = bi_q;
    tc_d   = tc_q;
    seen_d = seen_q;
    word_d = word_q;
    we_d   = 1'b0;
    addr_d = uart_addr;
    data_d = uart_data;
    ferr_d = uart_frame_error | rx_ferr;
    unique case (l_q)
      L_IDLE: begin
        if (session_start) begin
          l_d    = L_RECV;
          wa_d   = '0;
          bi_d   = '0;
          tc_d   = '0;
          seen_d = 1'b0;
          ferr_d = rx_ferr;
        end
      end
      L_RECV: begin
        if (bv_q) begin
          word_d[8*bi_q +: 8] = bd_q;
          bi_d   = bi_q + 1'b1;
          tc_d   = '0;
          seen_d = 1'b1;
          if (bi_q == 2'd3) begin
            l_d    = L_WRITE;
            we_d   = 1'b1;
            addr_d = wa_q;
            data_d = word_d;
          end
        end else if (seen_q) begin
          // Partial word is simply abandoned on timeout.
          if (tc_q == TW'(IDLE_TIMEOUT - 1)) l_d = L_DONE;
          else tc_d = tc_q + 1'b1;
        end
      end
      L_WRITE: begin
        bi_d = '0;
        wa_d = wa_q + 1'b1;
        l_d  = (&wa_q) ? L_DONE : L_RECV;
      end
      L_DONE: l_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q               <= L_IDLE;
      bv_q              <= 1'b0;
      bd_q              <= '0;
      wa_q              <= '0;
      bi_q              <= '0;
      tc_q              <= '0;
      seen_q            <= 1'b0;
      word_q            <= '0;
      uart_write_enable <= 1'b0;
      uart_addr         <= '0;
      uart_data         <= '0;
      uart_frame_error  <= 1'b0;
    end else begin
      l_q               <= l_d;
      bv_q              <= rx_valid;
      bd_q              <= rx_data;
      wa_q              <= wa_d;
      bi_q              <= bi_d;
      tc_q              <= tc_d;
      seen_q            <= seen_d;
      word_q            <= word_d;
      uart_write_enable <= we_d;
      uart_addr         <= addr_d;
      uart_data         <= data_d;
      uart_frame_error  <= ferr_d;
    end
  end

  assign uart_busy = (l_q == L_RECV) || (l_q == L_WRITE);
  assign uart_done = (l_q == L_DONE);

  // A byte needs 9+ baud periods, so none can land in the write cycle.
  a_no_byte_in_write: assert property (
    @(posedge clk) disable iff (rst) !((l_q == L_WRITE) && bv_q)
  );

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at DIV=16, ROM_DEPTH=2.
// Strobes and done pulses are logged by a monitor and checked in sequence.
module tb_uart_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        session_start;
  logic        uart_write_enable;
  logic [2:0]  uart_addr;
  logic [31:0] uart_data;
  logic        uart_busy;
  logic        uart_done;
  logic        uart_frame_error;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLK_FREQ    (16),
    .BAUD        (1),
    .ROM_DEPTH   (2),
    .IDLE_TIMEOUT(400)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .uart_rx          (uart_rx),
    .session_start    (session_start),
    .uart_write_enable(uart_write_enable),
    .uart_addr        (uart_addr),
    .uart_data        (uart_data),
    .uart_busy        (uart_busy),
    .uart_done        (uart_done),
    .uart_frame_error (uart_frame_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [2:0]  s_addr[$];
  logic [31:0] s_data[$];
  int          s_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (uart_write_enable === 1'b1) begin
      s_addr.push_back(uart_addr);
      s_data.push_back(uart_data);
      s_cyc.push_back(cyc);
    end
    if (uart_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(16);
    end
    uart_rx = stop;
    tick(16);
    uart_rx = 1'b1;
    tick(stop ? 4 : 20);
  endtask

  task automatic pulse_start();
    session_start = 1'b1;
    tick(1);
    session_start = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input int base, input string tag);
    int n;
    n = 0;
    while (done_cnt == base && n < 1000) begin
      tick(1);
      n++;
    end
    chk(tag, done_cnt, base + 1);
  endtask

  int bs, bd;
  logic [31:0] exp_w;
  logic [7:0]  b;

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    session_start = 1'b0;
    tick(3);
    chk("rst_we", uart_write_enable, 0);
    chk("rst_addr_data", {uart_addr, uart_data}, 0);
    chk("rst_flags", {uart_busy, uart_done, uart_frame_error}, 0);

    // reset while the receiver is mid data bits
    rst = 1'b0;
    tick(2);
    pulse_start();
    chk("open_busy", uart_busy, 1);
    uart_rx = 1'b0;
    tick(16);
    uart_rx = 1'b1;
    tick(16);
    uart_rx = 1'b0;
    tick(8);
    rst = 1'b1;
    tick(2);
    chk("midrst_outs", {uart_write_enable, uart_addr, uart_data}, 0);
    chk("midrst_flags", {uart_busy, uart_done, uart_frame_error}, 0);
    uart_rx = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);

    // basic session
    bs = s_addr.size();
    pulse_start();
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    chk("basic_n", s_addr.size() - bs, 1);
    if (s_addr.size() > bs) begin
      chk("basic_addr", s_addr[bs], 0);
      chk("basic_data", s_data[bs], 32'h12345678);
    end
    chk("basic_busy", uart_busy, 1);
    wait_done(done_cnt, "basic_timeout_done");
    tick(2);
    chk("basic_idle", uart_busy, 0);

    // full address space ends the session by itself
    bs = s_addr.size();
    bd = done_cnt;
    pulse_start();
    for (int k = 0; k < 32; k++) begin
      b = 8'hA0 + 8'(k);
      send_byte(b, 1'b1);
    end
    tick(4);
    chk("full_n", s_addr.size() - bs, 8);
    if (s_addr.size() >= bs + 8) begin
      for (int w = 0; w < 8; w++) begin
        exp_w = {8'hA3 + 8'(4*w), 8'hA2 + 8'(4*w),
                 8'hA1 + 8'(4*w), 8'hA0 + 8'(4*w)};
        chk($sformatf("full_addr%0d", w), s_addr[bs+w], w);
        chk($sformatf("full_data%0d", w), s_data[bs+w], exp_w);
      end
      chk("full_dmem_sel", s_addr[bs+4][2], 1);
      chk("full_done_lat", done_cyc, s_cyc[bs+7] + 1);
    end
    chk("full_done_n", done_cnt, bd + 1);
    chk("full_idle", uart_busy, 0);

    // bytes outside a session make no write
    bs = s_addr.size();
    send_byte(8'hC0, 1'b1);
    send_byte(8'hC1, 1'b1);
    send_byte(8'hC2, 1'b1);
    send_byte(8'hC3, 1'b1);
    chk("oos_n", s_addr.size() - bs, 0);

    // timeout with a partial second word
    bs = s_addr.size();
    bd = done_cnt;
    pulse_start();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    wait_done(bd, "to_done");
    tick(50);
    chk("to_n", s_addr.size() - bs, 1);
    if (s_addr.size() > bs) begin
      chk("to_addr", s_addr[bs], 0);
      chk("to_data", s_data[bs], 32'h44332211);
    end
    chk("to_done_once", done_cnt, bd + 1);
    chk("to_ferr", uart_frame_error, 0);

    // framing error, then a short glitch
    pulse_start();
    send_byte(8'h5A, 1'b0);
    chk("fe_set", uart_frame_error, 1);
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(200);
    bs = s_addr.size();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    chk("fe_n", s_addr.size() - bs, 1);
    if (s_addr.size() > bs) begin
      chk("fe_addr", s_addr[bs], 0);
      chk("fe_data", s_data[bs], 32'hDDCCBBAA);
    end
    chk("fe_sticky", uart_frame_error, 1);
    wait_done(done_cnt, "fe_done");
    tick(2);
    pulse_start();
    chk("fe_clear", uart_frame_error, 0);
    chk("busy_open", uart_busy, 1);

    // session_start while busy must not rewind the address
    bs = s_addr.size();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    pulse_start();
    send_byte(8'h05, 1'b1);
    send_byte(8'h06, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h08, 1'b1);
    chk("busy_n", s_addr.size() - bs, 2);
    if (s_addr.size() >= bs + 2) begin
      chk("busy_addr0", s_addr[bs], 0);
      chk("busy_data0", s_data[bs], 32'h04030201);
      chk("busy_addr1", s_addr[bs+1], 1);
      chk("busy_data1", s_data[bs+1], 32'h08070605);
    end
    wait_done(done_cnt, "busy_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
